// File: rtl/mul_div_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mul_div_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_funct3_t;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } md_state_t;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/mul_div_if.sv
// Request/response bundle between control logic, register file ports and mul_div.
interface mul_div_if;
    import mul_div_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_in,
        output busy, done, result, rd_out
    );

endinterface

// File: rtl/mul_div.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add / restoring divide on magnitudes,
// followed by a sign-fixup cycle that registers the result and rd for the write port.
module mul_div
    import mul_div_pkg::*;
#(
    parameter int unsigned XLEN = mul_div_pkg::XLEN
) (
    input logic      clk,
    input logic      rst,
    mul_div_if.slave bus
);

    localparam int unsigned CntW = $clog2(XLEN);

    md_state_t         state_q;
    md_funct3_t        op_q;
    logic [CntW-1:0]   cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   b_mag_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic [4:0]        rd_lat_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    // Request decode: sign flags, operand magnitudes and divide special cases.
    md_funct3_t      req_op;
    logic            a_signed;
    logic            b_signed;
    logic            req_neg_a;
    logic            req_neg_b;
    logic [XLEN-1:0] a_mag_in;
    logic [XLEN-1:0] b_mag_in;
    logic            div_by_zero;
    logic            div_ovf;

    assign req_op = md_funct3_t'(bus.funct3);

    always_comb begin
        a_signed    = req_op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        b_signed    = req_op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
        req_neg_a   = a_signed & bus.rs1_data[XLEN-1];
        req_neg_b   = b_signed & bus.rs2_data[XLEN-1];
        a_mag_in    = req_neg_a ? -bus.rs1_data : bus.rs1_data;
        b_mag_in    = req_neg_b ? -bus.rs2_data : bus.rs2_data;
        div_by_zero = bus.funct3[2] && (bus.rs2_data == '0);
        div_ovf     = (req_op == MD_DIV || req_op == MD_REM) &&
                      (bus.rs1_data == INT_MIN) && (bus.rs2_data == '1);
    end

    // One iteration step; divide keeps remainder:quotient in the upper:lower halves.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, b_mag_q} : {(XLEN+1){1'b0}});
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_mag_q};
        if (op_q[2]) begin
            if (!div_trial[XLEN]) begin
                acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_step = {acc_q[2*XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        prod       = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot       = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem        = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fix_result = '0;
        unique case (op_q)
            MD_MUL:                        fix_result = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  fix_result = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               fix_result = quot;
            MD_REM, MD_REMU:               fix_result = rem;
            default:                       fix_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= MD_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_mag_q  <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            rd_lat_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        op_q     <= req_op;
                        rd_lat_q <= bus.rd_in;
                        b_mag_q  <= b_mag_in;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        // Special cases preload the final remainder:quotient, no sign fixup.
                        if (div_by_zero) begin
                            acc_q   <= {bus.rs1_data, DIV0_QUOT};
                            neg_a_q <= 1'b0;
                            neg_b_q <= 1'b0;
                            state_q <= StFix;
                        end else if (div_ovf) begin
                            acc_q   <= {{XLEN{1'b0}}, INT_MIN};
                            neg_a_q <= 1'b0;
                            neg_b_q <= 1'b0;
                            state_q <= StFix;
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, a_mag_in};
                            neg_a_q <= req_neg_a;
                            neg_b_q <= req_neg_b;
                            state_q <= StCalc;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StCalc: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(XLEN - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    result_q <= fix_result;
                    rd_out_q <= rd_lat_q;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_mul_div.sv
// Directed self-checking bench for mul_div: arithmetic results, latency, handshake and reset abort.
module tb_mul_div;
    import mul_div_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    mul_div_if bus ();

    mul_div #(
        .XLEN (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a request through its accept edge; returns 1 edge counted.
    task automatic issue(input md_funct3_t f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.start    = 1'b1;
        bus.funct3   = f;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_in    = rd;
        step();
        bus.start    = 1'b0;
    endtask

    // Counts edges (accept edge included) until done is seen, bounded.
    task automatic wait_done(input int already, output int lat);
        lat = already;
        while (bus.done !== 1'b1 && lat < 80) begin
            step();
            lat++;
        end
    endtask

    task automatic run(input string tag, input md_funct3_t f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int exp_lat);
        int lat;
        issue(f, a, b, rd);
        wait_done(1, lat);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, bus.result, exp);
        check({tag, " rd_out"}, {27'd0, bus.rd_out}, {27'd0, rd});
        check({tag, " busy@done"}, {31'd0, bus.busy}, 32'd0);
        step();
        check({tag, " done 1-cycle"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int lat;
        int done_seen;
        tests        = 0;
        fails        = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.funct3   = 3'd0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.rd_in    = '0;
        step();
        step();
        rst = 1'b0;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset rd_out", {27'd0, bus.rd_out}, 32'd0);
        step();

        run("mul 7*-3", MD_MUL, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 34);
        run("mulh min*min", MD_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 34);
        run("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 34);
        run("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 34);
        run("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 34);
        run("rem -7/2", MD_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 34);
        run("divu 100/7", MD_DIVU, 32'd100, 32'd7, 5'd6, 32'd14, 34);
        run("remu 100/7", MD_REMU, 32'd100, 32'd7, 5'd7, 32'd2, 34);
        run("divu 5/0", MD_DIVU, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 2);
        run("rem 5/0", MD_REM, 32'd5, 32'd0, 5'd10, 32'd5, 2);
        run("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 2);
        run("rem ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'd0, 2);

        // start pulsed mid-operation is ignored; operand changes have no effect
        issue(MD_MUL, 32'd5, 32'd6, 5'd12);
        check("busy after accept", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < 9; i++) step();
        bus.start    = 1'b1;
        bus.funct3   = MD_MUL;
        bus.rs1_data = 32'd9;
        bus.rs2_data = 32'd9;
        bus.rd_in    = 5'd13;
        step();
        bus.start = 1'b0;
        wait_done(11, lat);
        check("ignored start latency", lat, 34);
        check("ignored start result", bus.result, 32'd30);
        check("ignored start rd_out", {27'd0, bus.rd_out}, 32'd12);

        // back-to-back accept during DONE
        issue(MD_MULHU, 32'h0001_0000, 32'h0003_0000, 5'd14);
        check("b2b no idle busy", {31'd0, bus.busy}, 32'd1);
        check("b2b old result held", bus.result, 32'd30);
        wait_done(1, lat);
        check("b2b latency", lat, 34);
        check("b2b result", bus.result, 32'd3);
        check("b2b rd_out", {27'd0, bus.rd_out}, 32'd14);
        step();

        // reset mid-divide aborts without done
        issue(MD_DIVU, 32'd100, 32'd7, 5'd15);
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort result", bus.result, 32'd0);
        check("abort rd_out", {27'd0, bus.rd_out}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) done_seen++;
            step();
        end
        check("abort no done", done_seen, 0);
        run("mul 3*4", MD_MUL, 32'd3, 32'd4, 5'd16, 32'd12, 34);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_div.md
# mul_div

Iterative RV32M multiply/divide unit sitting directly downstream of the register file read ports. It takes the rs1/rs2 read data plus the destination register index, computes the M-extension result over multiple cycles, and returns it with a one-cycle write strobe that drives the register file write port (`write_e`, `rd`, `write_d`). The unit handles one operation at a time, with a busy/done handshake toward the control logic.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; accepted only in IDLE or DONE.
- `funct3`  in  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_data`  in  32  operand A (register file `reg_data1`).
- `rs2_data`  in  32  operand B (register file `reg_data2`).
- `rd_in`  in  5  destination register index.
- `busy`  out  1  operation in flight (CALC or FIX).
- `done`  out  1  one-cycle strobe; drives register file `write_e`.
- `result`  out  32  result; drives register file `write_d`; held until the next `done`.
- `rd_out`  out  5  captured `rd_in`; drives register file `rd`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept rule: `start`=1 while in IDLE or DONE. On acceptance, latch `funct3`, `rd_in` and operand magnitudes plus sign flags.
  - Signed operands: rs1 for MUL/MULH/MULHSU/DIV/REM; rs2 for MUL/MULH/DIV/REM.
- From accept, go to CALC with counter = 0. Special cases go straight to FIX.
- Special cases (divide ops only):
  - divisor = 0: quotient = 0xFFFFFFFF, remainder = rs1_data.
  - Signed DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- CALC, multiply: radix-2 shift-add on 32-bit magnitudes into a 64-bit accumulator, one bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle, giving a 32-bit remainder.
- CALC lasts exactly 32 cycles, then goes to FIX.
- FIX applies the sign correction and registers the result:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - Result selection: MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- FIX always goes to DONE.
- DONE: `done`=1 for exactly that cycle. Next state is CALC/FIX if `start`=1 (back-to-back accept), otherwise IDLE.
- `start` in CALC/FIX is ignored; no queuing, and the in-flight operation is unaffected.
- `rd_out`=0 is allowed; the register file discards the write.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter 0.
- Reset during CALC/FIX aborts the operation, and no `done` is produced.

## Timing
- Accept edge E0. CALC updates on edges E1..E32, FIX on E33.
- `done`=1 during the cycle after E33, i.e. 34 cycles after accept.
- Special cases: FIX on E1, `done` during the cycle after E1, i.e. latency 2.
- `busy`=1 from after E0 until the FIX edge; `busy`=0 while `done`=1.
- `result`/`rd_out` update on the FIX edge, are valid with `done`, and hold afterwards.
- Operands are sampled only at accept; later changes on `rs1_data`/`rs2_data` have no effect.

## Structure
- `mul_div_pkg` contains:
  - `XLEN`
  - the `funct3` enum (`MD_MUL` … `MD_REMU`)
  - the state enum `md_state_t`
  - the constants `DIV0_QUOT` = 0xFFFFFFFF and `INT_MIN` = 0x80000000.
- Single module with no sub-module. Sign fixup and special-case detection are inline combinational logic.
- One shared 64-bit working register: multiplier product, or remainder:quotient for divide.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3): `result`=0xFFFFFFEB, `rd_out`=`rd_in`, `done` exactly 34 cycles after accept, for 1 cycle.
- High products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed division: DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- Special cases, each with `done` 2 cycles after accept:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- `start` pulsed with new operands at cycle 10 of a MUL: ignored, and the original result is returned. `start` during DONE: the second operation completes 34 cycles later, with no IDLE cycle between.
- `rst` asserted at cycle 10 of a DIV:
  - Next cycle: `busy`=0, `done`=0, `result`=0, `rd_out`=0, and no `done` ever appears for the aborted operation.
  - A subsequent MUL 3×4 returns 12.
